// File: rtl/vblank_arbiter.sv
// Purpose : shares the vertical-blanking update window among NUM_REQ requesters
//           and swaps the displayed frame buffer once per window when asked.
// Latency : grant_out asserts 1 cycle after the ARB pick; all outputs are registered.
// Backpr. : none; a grant is held until done_in or window close, and the
//           requester cannot stall the timing generator.
// Ports   : vclock_in/rst_n_in clock and async active-low reset;
//           hcount_in/vcount_in raster position;
//           req_in/done_in per-requester request and completion;
//           swap_req_in buffer-swap request;
//           grant_out one-hot grant; frame_sel_out displayed buffer;
//           swap_ack_out, frame_start_out and timeout_out one-cycle pulses;
//           timeout_id_out index of the last revoked requester.
module vblank_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DISPLAY_HEIGHT = 768,
  parameter int GUARD_LINE     = 803,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               vclock_in,
  input  logic               rst_n_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] done_in,
  input  logic               swap_req_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic               frame_sel_out,
  output logic               swap_ack_out,
  output logic               frame_start_out,
  output logic               timeout_out,
  output logic [IDW-1:0]     timeout_id_out
);

  typedef enum logic [2:0] {IDLE, SWAP, ARB, GRANT, HOLD} state_t;

  localparam logic [9:0] DH_V = 10'(DISPLAY_HEIGHT);
  localparam logic [9:0] GL_V = 10'(GUARD_LINE);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_q, last_d;
  logic               pending_q, pending_d;
  logic               frame_sel_q, frame_sel_d;
  logic               swap_ack_q, swap_ack_d;
  logic               frame_start_q, frame_start_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     timeout_id_q, timeout_id_d;

  logic               window_open;
  logic               past_guard;
  logic               pick_vld;
  logic [IDW-1:0]     pick_idx;
  logic [IDW-1:0]     cand;

  assign window_open = (vcount_in >= DH_V);
  assign past_guard  = (vcount_in > GL_V);

  // Round-robin search starting after the last completed grant. The loop runs
  // from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDW'((int'(last_q) + i) % NUM_REQ);
      if (req_in[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    pending_d     = pending_q | swap_req_in;
    frame_sel_d   = frame_sel_q;
    swap_ack_d    = 1'b0;
    frame_start_d = (hcount_in == '0) && (vcount_in == '0);
    timeout_d     = 1'b0;
    timeout_id_d  = timeout_id_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (window_open) begin
          if (pending_q) begin
            // Toggle is registered on entry so frame_sel_out and swap_ack_out
            // change during the single SWAP cycle itself.
            state_d     = SWAP;
            frame_sel_d = ~frame_sel_q;
            swap_ack_d  = 1'b1;
          end else begin
            state_d = ARB;
          end
        end
      end
      SWAP: begin
        // A request arriving while swapping is kept for the next window.
        pending_d = swap_req_in;
        state_d   = ARB;
      end
      ARB: begin
        if (!window_open) begin
          state_d = IDLE;
        end else if (past_guard) begin
          state_d = HOLD;
        end else if (pick_vld) begin
          grant_d    = NUM_REQ'(1) << pick_idx;
          grant_id_d = pick_idx;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Completion takes priority over window close on the same cycle.
        if (done_in[grant_id_q]) begin
          grant_d = '0;
          last_d  = grant_id_q;
          state_d = window_open ? ARB : IDLE;
        end else if (!window_open) begin
          grant_d      = '0;
          timeout_d    = 1'b1;
          timeout_id_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      HOLD: begin
        if (!window_open) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge vclock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      last_q        <= IDW'(NUM_REQ - 1);
      pending_q     <= 1'b0;
      frame_sel_q   <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      frame_sel_q   <= frame_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      timeout_q     <= timeout_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign grant_out       = grant_q;
  assign frame_sel_out   = frame_sel_q;
  assign swap_ack_out    = swap_ack_q;
  assign frame_start_out = frame_start_q;
  assign timeout_out     = timeout_q;
  assign timeout_id_out  = timeout_id_q;

endmodule
